jtag_readback_chain2: RTL and testbench

JTAG user data register on ER2 that returns data from the fabric to the host. It complements the ER1 host-to-fabric LED/data chain. Fabric logic pushes 30-bit words into a small FIFO through a valid/ready port. Each ER2 DR scan captures the FIFO head plus status into a shift register and clocks it out on JTD2; the word is popped only when that scan reaches Update-DR.

---
 rtl/jtag_chain_pkg.sv | 26 ++
 rtl/jtag_readback_chain2_if.sv | 13 +
 rtl/jtag_readback_chain2_sync_fifo.sv | 57 +++++
 rtl/jtag_readback_chain2.sv | 89 ++++++++
 tb/tb_jtag_readback_chain2.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/jtag_chain_pkg.sv
// Shared definitions for the JTAG user data register chains (ER1/ER2).
package jtag_chain_pkg;

  // Default payload width of one fabric word on the readback chain
  localparam int DEFAULT_DATA_W = 30;

  // Frame field offsets, LSB is shifted out first
  localparam int VALID_BIT = 0;
  localparam int CNT_LSB   = 1;

  // Head word sits directly above the occupancy field
  function automatic int data_lsb(input int cnt_w);
    return CNT_LSB + cnt_w;
  endfunction

  localparam int DATA_LSB = data_lsb(3);

  // User data register chain identifiers
  typedef enum logic [1:0] {
    CHAIN_ER1 = 2'd1,
    CHAIN_ER2 = 2'd2
  } chain_id_e;

  localparam chain_id_e ER2_CHAIN_ID = CHAIN_ER2;

endpackage

// File: rtl/jtag_readback_chain2_if.sv
// Fabric-side write port of the ER2 readback chain: valid/ready push plus occupancy.
interface jtag_readback_chain2_if #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 3
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [CNT_W-1:0]  fill;

  modport master (output wr_valid, output wr_data, input wr_ready, input fill);
  modport slave  (input wr_valid, input wr_data, output wr_ready, output fill);
endinterface

// File: rtl/jtag_readback_chain2_sync_fifo.sv
// Small synchronous FIFO: power-of-two depth, wrapping pointers, explicit fill count.
module sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 30,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_fill,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_fill;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_fill == CNT_W'(DEPTH));
  assign o_empty = (r_fill == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_fill  = r_fill;

  // Storage write on an accepted push
  // NOTE: the data array carries no reset; only pointers and fill define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves fill unchanged
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/jtag_readback_chain2.sv
// ER2 user data register: captures the FIFO head plus status, shifts it out on JTD2,
// and pops the word only when a scan that captured valid data reaches Update-DR.
module jtag_readback_chain2
  import jtag_chain_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4,
  localparam int CNT_W   = $clog2(DEPTH) + 1,
  localparam int FRAME_W = DATA_W + CNT_W + 1
) (
  input  logic JTCK,
  input  logic JRSTN,
  input  logic JTDI,
  input  logic JSHIFT,
  input  logic JUPDATE,
  input  logic JCE2,
  output logic JTD2,
  jtag_readback_chain2_if.slave wr_if
);

  localparam int FRAME_DATA_LSB = data_lsb(CNT_W);

  logic [FRAME_W-1:0] r_shift;
  logic               r_pend;
  logic [FRAME_W-1:0] w_frame;
  logic [DATA_W-1:0]  w_head;
  logic [CNT_W-1:0]   w_fill;
  logic               w_full;
  logic               w_empty;
  logic               w_capture;
  logic               w_shift;
  logic               w_pop;

  assign w_capture = JCE2 && !JSHIFT;
  assign w_shift   = JCE2 && JSHIFT;
  // JUPDATE is shared with ER1 and other IRs, so only a scan that captured data may pop
  assign w_pop     = JUPDATE && r_pend;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (JTCK),
    .rst_n   (JRSTN),
    .i_push  (wr_if.wr_valid),
    .i_data  (wr_if.wr_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_fill  (w_fill),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign wr_if.wr_ready = !w_full;
  assign wr_if.fill     = w_fill;
  assign JTD2           = r_shift[0];

  // Assemble the capture frame from the FIFO head and status fields
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_frame                            = '0;
    w_frame[VALID_BIT]                 = 1'b1;
    w_frame[CNT_LSB +: CNT_W]          = w_fill;
    w_frame[FRAME_DATA_LSB +: DATA_W]  = w_head;
  end

  // Capture loads the frame (or zeros when empty); shift moves it toward JTD2
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      r_shift <= '0;
    end else if (w_capture) begin
      r_shift <= w_empty ? '0 : w_frame;
    end else if (w_shift) begin
      r_shift <= {JTDI, r_shift[FRAME_W-1:1]};
    end
  end

  // pend marks a captured-but-not-yet-consumed head; repeated captures keep it set
  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      r_pend <= 1'b0;
    end else if (w_capture && !w_empty) begin
      r_pend <= 1'b1;
    end else if (w_pop) begin
      r_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_readback_chain2.sv
// Directed bench for the ER2 readback chain with hand-computed frames.
module tb_jtag_readback_chain2;

  localparam int DATA_W  = 30;
  localparam int CNT_W   = 3;
  localparam int FRAME_W = 34;

  logic JTCK = 1'b0;
  logic JRSTN, JTDI, JSHIFT, JUPDATE, JCE2, JTD2;

  int checks   = 0;
  int failures = 0;

  jtag_readback_chain2_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) wr_if ();

  jtag_readback_chain2 dut (
    .JTCK    (JTCK),
    .JRSTN   (JRSTN),
    .JTDI    (JTDI),
    .JSHIFT  (JSHIFT),
    .JUPDATE (JUPDATE),
    .JCE2    (JCE2),
    .JTD2    (JTD2),
    .wr_if   (wr_if)
  );

  always #5 JTCK = ~JTCK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled and inputs driven off the edge
  task automatic cyc();
    @(posedge JTCK);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = w;
    cyc();
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic pulse_update();
    JUPDATE = 1'b1;
    cyc();
    JUPDATE = 1'b0;
  endtask

  // Capture, 34 shift edges reading bit k after the k-th edge, optional Update-DR
  task automatic scan(output logic [FRAME_W-1:0] f, input bit do_update);
    JCE2 = 1'b1;
    JSHIFT = 1'b0;
    cyc();
    f[0] = JTD2;
    JSHIFT = 1'b1;
    for (int k = 1; k <= FRAME_W; k++) begin
      JTDI = k[0];
      cyc();
      if (k < FRAME_W) f[k] = JTD2;
    end
    JSHIFT = 1'b0;
    JCE2 = 1'b0;
    JTDI = 1'b0;
    if (do_update) pulse_update();
  endtask

  function automatic logic [FRAME_W-1:0] frm(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c);
    return {d, c, 1'b1};
  endfunction

  logic [FRAME_W-1:0] f;

  initial begin
    JRSTN = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JCE2 = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    cyc();
    cyc();
    JRSTN = 1'b1;
    cyc();

    // Reset state
    check("rst_jtd2", JTD2, 0);
    check("rst_fill", wr_if.fill, 0);
    check("rst_ready", wr_if.wr_ready, 1);

    // Empty capture returns an all-zero frame
    scan(f, 1'b1);
    check("empty_frame", f, 0);
    check("empty_fill", wr_if.fill, 0);
    check("empty_ready", wr_if.wr_ready, 1);

    // Single word round trip
    push(30'h2AAAAAAA);
    check("one_fill", wr_if.fill, 1);
    scan(f, 1'b1);
    check("one_frame", f, frm(30'h2AAAAAAA, 3'd1));
    check("one_popped", wr_if.fill, 0);

    // Fill to full, then drain in order with decreasing occupancy
    for (int i = 1; i <= 4; i++) push(DATA_W'(i));
    check("full_fill", wr_if.fill, 4);
    check("full_ready", wr_if.wr_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      scan(f, 1'b1);
      check($sformatf("drain%0d", i), f, frm(DATA_W'(i), CNT_W'(5 - i)));
    end
    scan(f, 1'b1);
    check("drain_empty", f, 0);
    check("drain_fill", wr_if.fill, 0);

    // Update without a capture (ER1 traffic) must not pop
    push(30'd5);
    push(30'd6);
    pulse_update();
    check("er1_nopop", wr_if.fill, 2);
    // Two captures then one update pop exactly once
    JCE2 = 1'b1; cyc(); cyc(); JCE2 = 1'b0;
    check("dbl_cap_frame_bit0", JTD2, 1);
    pulse_update();
    check("dbl_cap_pop", wr_if.fill, 1);
    pulse_update();
    check("dbl_cap_once", wr_if.fill, 1);
    scan(f, 1'b1);
    check("dbl_cap_next", f, frm(30'd6, 3'd1));

    // Full FIFO: push offered on the pop edge is refused, accepted on the next
    for (int i = 10; i <= 13; i++) push(DATA_W'(i));
    JCE2 = 1'b1; cyc(); JCE2 = 1'b0;
    JUPDATE = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 30'd14;
    cyc();
    JUPDATE = 1'b0;
    check("pp_fill_after_pop", wr_if.fill, 3);
    check("pp_ready_after_pop", wr_if.wr_ready, 1);
    cyc();
    wr_if.wr_valid = 1'b0;
    check("pp_fill_after_push", wr_if.fill, 4);
    for (int i = 11; i <= 14; i++) begin
      scan(f, 1'b1);
      check($sformatf("pp_order%0d", i), f, frm(DATA_W'(i), CNT_W'(15 - i)));
    end

    // Asynchronous reset mid-shift with three words queued
    push(30'h3FFFFFFF);
    push(30'd21);
    push(30'd22);
    JCE2 = 1'b1;
    cyc();
    JSHIFT = 1'b1;
    cyc();
    cyc();
    #2;
    JRSTN = 1'b0;
    #1;
    check("abort_jtd2", JTD2, 0);
    check("abort_fill", wr_if.fill, 0);
    check("abort_ready", wr_if.wr_ready, 1);
    JSHIFT = 1'b0;
    JCE2 = 1'b0;
    cyc();
    JRSTN = 1'b1;
    cyc();
    scan(f, 1'b1);
    check("abort_empty_frame", f, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
